// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches the two instruction bytes at the core PC from a
// byte-wide program memory over a req/ack handshake. Presents them with a
// tag-compared valid flag and a stall, and flags memory that never acknowledges.
// Build option: define IFETCH_PREFETCH_EN to add a one-entry sequential
// prefetch buffer (tag+2/tag+3) so straight-line code advances without stalling.
module instr_fetch_unit #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] i_pc_addr,
   output logic [7:0] o_opcode1,
   output logic [7:0] o_opcode2,
   output logic       o_instr_valid,
   output logic       o_stall,
   output logic [7:0] o_mem_addr,
   output logic       o_mem_req,
   input  logic       i_mem_ack,
   input  logic [7:0] i_mem_rdata,
   output logic       o_fetch_err
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 8;

   localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_FETCH_HI = 3'd1;
   localparam logic [2:0] S_GAP      = 3'd2;
   localparam logic [2:0] S_FETCH_LO = 3'd3;
   localparam logic [2:0] S_VALID    = 3'd4;

   // Main fetch registers
   logic [2:0]    r_state;
   logic [AW-1:0] r_tag;
   logic [DW-1:0] r_hi;
   logic [DW-1:0] r_lo;
   logic [CW-1:0] r_wait;
   logic          r_mem_req;
   logic [AW-1:0] r_mem_addr;
   logic          r_fetch_err;

   // Next-state values
   logic [2:0]    w_state_nxt;
   logic [AW-1:0] w_tag_nxt;
   logic [DW-1:0] w_hi_nxt;
   logic [DW-1:0] w_lo_nxt;
   logic [CW-1:0] w_wait_nxt;
   logic          w_req_nxt;
   logic [AW-1:0] w_addr_nxt;
   logic          w_err_nxt;

   logic [CW-1:0] w_wait_inc;
   logic          w_timeout;
   logic          w_tag_hit;

`ifdef IFETCH_PREFETCH_EN
   localparam logic [1:0] PF_IDLE = 2'd0;
   localparam logic [1:0] PF_HI   = 2'd1;
   localparam logic [1:0] PF_GAP  = 2'd2;
   localparam logic [1:0] PF_LO   = 2'd3;

   logic [1:0]    r_pf_st;
   logic [AW-1:0] r_pf_tag;
   logic [DW-1:0] r_pf_hi;
   logic [DW-1:0] r_pf_lo;
   logic          r_pf_full;

   logic [1:0]    w_pf_st_nxt;
   logic [AW-1:0] w_pf_tag_nxt;
   logic [DW-1:0] w_pf_hi_nxt;
   logic [DW-1:0] w_pf_lo_nxt;
   logic          w_pf_full_nxt;

   logic          w_pf_hit;
   logic          w_pf_keep;
   logic          w_pf_sel;
`endif

   // Handshake wait tracking and tag compare
   assign w_wait_inc = r_wait + CW'(1);
   assign w_timeout  = r_mem_req && !i_mem_ack && (w_wait_inc == WAIT_LIM);
   assign w_tag_hit  = (i_pc_addr == r_tag);

`ifdef IFETCH_PREFETCH_EN
   // Prefetch hit needs a completed buffer; keep an in-flight prefetch alive
   // while the core is on the current line or waiting on the prefetched one
   assign w_pf_hit  = r_pf_full && (i_pc_addr == r_pf_tag);
   assign w_pf_keep = w_tag_hit || (i_pc_addr == r_pf_tag);
   assign w_pf_sel  = (r_state == S_VALID) && !w_tag_hit && w_pf_hit;
`endif

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt = r_state;
      w_tag_nxt   = r_tag;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      w_addr_nxt  = r_mem_addr;
      w_req_nxt   = 1'b0;
      w_err_nxt   = r_fetch_err;
      w_wait_nxt  = (r_mem_req && !i_mem_ack) ? w_wait_inc : '0;
`ifdef IFETCH_PREFETCH_EN
      w_pf_st_nxt   = r_pf_st;
      w_pf_tag_nxt  = r_pf_tag;
      w_pf_hi_nxt   = r_pf_hi;
      w_pf_lo_nxt   = r_pf_lo;
      w_pf_full_nxt = r_pf_full;
`endif
      case (r_state)
         S_IDLE: begin
            w_tag_nxt   = i_pc_addr;
            w_addr_nxt  = i_pc_addr;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_FETCH_HI;
         end
         S_FETCH_HI: begin
            if (i_mem_ack) begin
               w_hi_nxt    = i_mem_rdata;
               w_state_nxt = S_GAP;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_wait_nxt  = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_req_nxt = 1'b1;
            end
         end
         S_GAP: begin
            w_addr_nxt  = r_tag + AW'(1);
            w_req_nxt   = 1'b1;
            w_state_nxt = S_FETCH_LO;
         end
         S_FETCH_LO: begin
            if (i_mem_ack) begin
               w_lo_nxt    = i_mem_rdata;
               w_state_nxt = S_VALID;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_wait_nxt  = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_req_nxt = 1'b1;
            end
         end
         S_VALID: begin
`ifdef IFETCH_PREFETCH_EN
            case (r_pf_st)
               PF_IDLE: begin
                  if (w_tag_hit) begin
                     if (!r_pf_full) begin
                        w_pf_tag_nxt = r_tag + AW'(2);
                        w_addr_nxt   = r_tag + AW'(2);
                        w_req_nxt    = 1'b1;
                        w_pf_st_nxt  = PF_HI;
                     end
                  end else if (w_pf_hit) begin
                     // Promote prefetch buffer; next prefetch starts next cycle
                     w_tag_nxt     = r_pf_tag;
                     w_hi_nxt      = r_pf_hi;
                     w_lo_nxt      = r_pf_lo;
                     w_pf_full_nxt = 1'b0;
                  end else begin
                     w_pf_full_nxt = 1'b0;
                     w_state_nxt   = S_IDLE;
                  end
               end
               PF_HI: begin
                  if (i_mem_ack) begin
                     w_pf_hi_nxt = i_mem_rdata;
                     if (w_pf_keep) begin
                        w_pf_st_nxt = PF_GAP;
                     end else begin
                        w_pf_st_nxt = PF_IDLE;
                        w_state_nxt = S_IDLE;
                     end
                  end else if (w_timeout) begin
                     w_err_nxt   = 1'b1;
                     w_wait_nxt  = '0;
                     w_pf_st_nxt = PF_IDLE;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_req_nxt = 1'b1;
                  end
               end
               PF_GAP: begin
                  if (w_pf_keep) begin
                     w_addr_nxt  = r_pf_tag + AW'(1);
                     w_req_nxt   = 1'b1;
                     w_pf_st_nxt = PF_LO;
                  end else begin
                     w_pf_st_nxt = PF_IDLE;
                     w_state_nxt = S_IDLE;
                  end
               end
               PF_LO: begin
                  if (i_mem_ack) begin
                     w_pf_lo_nxt = i_mem_rdata;
                     w_pf_st_nxt = PF_IDLE;
                     if (w_pf_keep) begin
                        w_pf_full_nxt = 1'b1;
                     end else begin
                        w_state_nxt = S_IDLE;
                     end
                  end else if (w_timeout) begin
                     w_err_nxt   = 1'b1;
                     w_wait_nxt  = '0;
                     w_pf_st_nxt = PF_IDLE;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_req_nxt = 1'b1;
                  end
               end
               default: begin
                  w_pf_st_nxt = PF_IDLE;
               end
            endcase
`else
            if (!w_tag_hit) begin
               w_state_nxt = S_IDLE;
            end
`endif
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_tag       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_wait      <= '0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_fetch_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tag       <= w_tag_nxt;
         r_hi        <= w_hi_nxt;
         r_lo        <= w_lo_nxt;
         r_wait      <= w_wait_nxt;
         r_mem_req   <= w_req_nxt;
         r_mem_addr  <= w_addr_nxt;
         r_fetch_err <= w_err_nxt;
      end
   end

`ifdef IFETCH_PREFETCH_EN
   // Prefetch buffer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pf_st   <= PF_IDLE;
         r_pf_tag  <= '0;
         r_pf_hi   <= '0;
         r_pf_lo   <= '0;
         r_pf_full <= 1'b0;
      end else begin
         r_pf_st   <= w_pf_st_nxt;
         r_pf_tag  <= w_pf_tag_nxt;
         r_pf_hi   <= w_pf_hi_nxt;
         r_pf_lo   <= w_pf_lo_nxt;
         r_pf_full <= w_pf_full_nxt;
      end
   end

   // Valid and opcodes follow the PC combinationally from either buffer
   assign o_instr_valid = (r_state == S_VALID) && (w_tag_hit || w_pf_hit);
   assign o_opcode1     = w_pf_sel ? r_pf_hi : r_hi;
   assign o_opcode2     = w_pf_sel ? r_pf_lo : r_lo;
`else
   // Valid follows the PC combinationally so stale bytes are never flagged
   assign o_instr_valid = (r_state == S_VALID) && w_tag_hit;
   assign o_opcode1     = r_hi;
   assign o_opcode2     = r_lo;
`endif

   assign o_stall     = ~o_instr_valid;
   assign o_mem_req   = r_mem_req;
   assign o_mem_addr  = r_mem_addr;
   assign o_fetch_err = r_fetch_err;

endmodule
